ex_alu_seq: RTL and testbench
=============================

# ex_alu_seq

Execute-stage arithmetic unit fed directly by the ALU control decoder: consumes the 4-bit ALU control code together with the two operands and a shift amount, and produces a 64-bit result, a zero indication and an NZVC flag register. Logical and add/sub operations complete in one cycle. LSL/LSR are performed iteratively, one bit per cycle, to keep the shifter small. A valid/ready handshake on both sides lets the pipeline controller stall EX while a shift is in progress.

## Interface
- DATA_W, 64, operand/result width
- SHAMT_W, 6, shift-amount width; must satisfy 2^SHAMT_W ≥ DATA_W
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request this cycle
- alu_ctl  in  4  operation code, using the `ALU_*` macros in common.vh
- op_a  in  DATA_W  operand A (Rn)
- op_b  in  DATA_W  operand B (Rm or immediate)
- shamt  in  SHAMT_W  shift amount for LSL/LSR
- set_flags  in  1  update NZVC on completion (ADDS/SUBS/ANDS/…IS forms)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  DATA_W  registered result
- zero  out  1  (result == 0), combinational from the result register
- flags  out  4  {N,Z,V,C} architectural flag register
- illegal  out  1  completed op had an unsupported alu_ctl; valid with out_valid

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. Reset state is IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- A transfer is accepted when in_valid && in_ready. On acceptance, alu_ctl, op_a, op_b, shamt and set_flags are latched.
- Non-shift ops, or a shift with shamt==0:
  - result is computed and registered in the accept cycle; next state is DONE.
- LSL/LSR with shamt≠0:
  - result is loaded with op_a; a down-counter is loaded with shamt; next state is SHIFT.
  - Each SHIFT cycle shifts result by one bit (LSL: left, zero fill; LSR: logical right, zero fill) and decrements the counter.
  - When the counter reaches 1 the last shift is applied and the FSM enters DONE.
- Operation semantics:
  - ADD: a+b.
  - SUB: a−b.
  - AND: a&b.
  - OR: a|b.
  - PASS: b.
  - NONE or any other code: result 0 and illegal=1.
- Flags are updated only on DONE entry when latched set_flags=1 and the op is ADD, SUB or AND:
  - N = result[DATA_W-1]; Z = (result==0).
  - ADD: C is the carry out of bit DATA_W-1; V = (a_msb==b_msb) && (r_msb≠a_msb).
  - SUB: C = no-borrow (a ≥ b unsigned); V = (a_msb≠b_msb) && (r_msb≠a_msb).
  - AND: V=0, C=0.
  - All other cases leave the flags unchanged.
- In DONE, out_valid=1 and result and illegal are held stable until out_ready.
  - out_ready && !in_valid: go to IDLE.
  - out_ready && in_valid: accept the new op in the same cycle (back-to-back).
- in_valid during SHIFT is ignored (in_ready=0); the requester must hold it.

## Timing
- Reset (rst_n low at a clk edge): state=IDLE, result=0, flags=0, illegal=0, counter=0.
  - Resulting outputs: out_valid=0, in_ready=1, zero=1.
- Reset mid-SHIFT or in DONE aborts the operation; the pending result is discarded.
- Latency from accept to out_valid:
  - 1 cycle for non-shift ops and for shamt=0.
  - shamt+1 cycles for LSL/LSR with shamt≠0; maximum 64 with the default parameters.
- Throughput: one op per cycle for single-cycle ops while out_ready is held high.
- Flags become visible the cycle out_valid first rises and are stable thereafter.
- Arithmetic is modulo 2^DATA_W. Shifts by shamt ≥ DATA_W produce 0. The counter width is SHAMT_W.

## Test plan
- ADD with set_flags, a=0x7FFF_FFFF_FFFF_FFFF, b=1 → next cycle out_valid=1, result=0x8000_0000_0000_0000, flags NZVC=1010.
- SUB with set_flags, a=5, b=5 → result=0, zero=1, NZVC=0101. Then SUB with set_flags, a=3, b=5 → result=0xFFFF_FFFF_FFFF_FFFE, NZVC=1000.
- LSL, a=1, shamt=63, out_ready=1 → in_ready low for 63 cycles, out_valid on cycle 64, result=0x8000_0000_0000_0000. LSR, a=0xF0, shamt=4 → result=0x0F after 5 cycles.
- Back-to-back AND, OR, PASS with in_valid and out_ready held high → results on consecutive cycles. Then deassert out_ready for 3 cycles → result and out_valid held, in_ready=0, no flag change.
- alu_ctl=`ALU_NONE` with set_flags=1 → result=0, illegal=1, flags unchanged from the prior value.
- Pull rst_n low during cycle 10 of LSL shamt=40 → next cycle state IDLE, out_valid=0, result=0, flags=0, in_ready=1. A subsequent ADD 2+3 returns 5.

Source files
------------

// File: rtl/ex_alu_seq_if.sv
// Request/response bundle between the EX-stage controller and the sequential ALU.
// The master side issues operations and consumes results; the slave side is the ALU.
interface ex_alu_seq_if #(
    parameter int DATA_W  = 64,
    parameter int SHAMT_W = 6
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          alu_ctl;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [SHAMT_W-1:0]  shamt;
    logic                set_flags;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   result;
    logic                zero;
    logic [3:0]          flags;
    logic                illegal;

    modport master (
        output in_valid, alu_ctl, op_a, op_b, shamt, set_flags, out_ready,
        input  in_ready, out_valid, result, zero, flags, illegal
    );

    modport slave (
        input  in_valid, alu_ctl, op_a, op_b, shamt, set_flags, out_ready,
        output in_ready, out_valid, result, zero, flags, illegal
    );
endinterface

// File: rtl/ex_alu_seq.sv
// EX-stage ALU: single-cycle logic/add/sub, bit-serial LSL/LSR, NZVC flag register.
// Valid/ready on both sides so the pipeline can stall while a shift runs.
module ex_alu_seq #(
    parameter int DATA_W  = 64,
    parameter int SHAMT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_alu_seq_if.slave      bus
);
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_LSL  = 4'b0011;
    localparam logic [3:0] ALU_LSR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   result_reg, result_next;
    logic [3:0]          flags_reg, flags_next;
    logic                illegal_reg, illegal_next;
    logic [SHAMT_W-1:0]  cnt_reg, cnt_next;
    logic                shl_reg, shl_next;

    logic                in_ready;
    logic                accept;
    logic                is_shift;
    logic [DATA_W:0]     sum_ext;
    logic [DATA_W:0]     diff_ext;
    logic [DATA_W-1:0]   alu_res;
    logic [3:0]          alu_flags;
    logic                alu_upd;
    logic                alu_ill;
    logic                a_msb, b_msb;

    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign is_shift = (bus.alu_ctl == ALU_LSL) || (bus.alu_ctl == ALU_LSR);
    assign a_msb    = bus.op_a[DATA_W-1];
    assign b_msb    = bus.op_b[DATA_W-1];
    // One extra bit captures carry-out for ADD and borrow for SUB.
    assign sum_ext  = {1'b0, bus.op_a} + {1'b0, bus.op_b};
    assign diff_ext = {1'b0, bus.op_a} - {1'b0, bus.op_b};

    always_comb begin
        alu_res   = '0;
        alu_flags = flags_reg;
        alu_upd   = 1'b0;
        alu_ill   = 1'b0;
        case (bus.alu_ctl)
            ALU_ADD: begin
                alu_res   = sum_ext[DATA_W-1:0];
                alu_upd   = 1'b1;
                alu_flags = {alu_res[DATA_W-1], alu_res == '0,
                             (a_msb == b_msb) && (alu_res[DATA_W-1] != a_msb),
                             sum_ext[DATA_W]};
            end
            ALU_SUB: begin
                alu_res   = diff_ext[DATA_W-1:0];
                alu_upd   = 1'b1;
                alu_flags = {alu_res[DATA_W-1], alu_res == '0,
                             (a_msb != b_msb) && (alu_res[DATA_W-1] != a_msb),
                             ~diff_ext[DATA_W]};
            end
            ALU_AND: begin
                alu_res   = bus.op_a & bus.op_b;
                alu_upd   = 1'b1;
                alu_flags = {alu_res[DATA_W-1], alu_res == '0, 1'b0, 1'b0};
            end
            ALU_OR:   alu_res = bus.op_a | bus.op_b;
            ALU_PASS: alu_res = bus.op_b;
            // Only reached as a finished result when shamt is zero.
            ALU_LSL, ALU_LSR: alu_res = bus.op_a;
            default:  alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        result_next  = result_reg;
        flags_next   = flags_reg;
        illegal_next = illegal_reg;
        cnt_next     = cnt_reg;
        shl_next     = shl_reg;

        case (state_reg)
            IDLE: ;
            SHIFT: begin
                result_next = shl_reg ? (result_reg << 1) : (result_reg >> 1);
                cnt_next    = cnt_reg - SHAMT_W'(1);
                if (cnt_reg == SHAMT_W'(1))
                    state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready && !bus.in_valid)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Acceptance overrides the DONE->IDLE exit, giving back-to-back issue.
        if (accept) begin
            illegal_next = alu_ill;
            if (is_shift && (bus.shamt != '0)) begin
                result_next = bus.op_a;
                cnt_next    = bus.shamt;
                shl_next    = (bus.alu_ctl == ALU_LSL);
                state_next  = SHIFT;
            end else begin
                result_next = alu_res;
                state_next  = DONE;
                if (bus.set_flags && alu_upd)
                    flags_next = alu_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            flags_reg   <= '0;
            illegal_reg <= 1'b0;
            cnt_reg     <= '0;
            shl_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            result_reg  <= result_next;
            flags_reg   <= flags_next;
            illegal_reg <= illegal_next;
            cnt_reg     <= cnt_next;
            shl_reg     <= shl_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.zero      = (result_reg == '0);
    assign bus.flags     = flags_reg;
    assign bus.illegal   = illegal_reg;
endmodule

// File: tb/tb_ex_alu_seq.sv
// Scoreboard bench for ex_alu_seq: directed cases then randomized ops,
// checked against a plain-arithmetic reference model.
module tb_ex_alu_seq;
    localparam int DATA_W  = 64;
    localparam int SHAMT_W = 6;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_LSL  = 4'b0011;
    localparam logic [3:0] ALU_LSR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    localparam logic signed [65:0] SMAX = 66'sd9223372036854775807;
    localparam logic signed [65:0] SMIN = -66'sd9223372036854775808;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  flg;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_alu_seq_if #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) bus ();

    ex_alu_seq #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        sb[$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          cyc = 0;
    logic [3:0]  mflags = 4'b0;
    logic        random_ready = 1'b0;
    logic        ready_force = 1'b0;
    logic        need_start = 1'b1;
    int          start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: architectural behaviour from plain arithmetic.
    task automatic model(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] sh, input logic sf, output exp_t e);
        logic signed [65:0] sa, sb2, s;
        logic [63:0] r;
        logic v, c, upd;
        sa = $signed(a);
        sb2 = $signed(b);
        r = '0; v = 1'b0; c = 1'b0; upd = 1'b0;
        e.ill = 1'b0;
        e.lat = 0;
        case (ctl)
            ALU_ADD:  begin r = a + b; s = sa + sb2; v = (s > SMAX) || (s < SMIN); c = (r < a); upd = 1'b1; end
            ALU_SUB:  begin r = a - b; s = sa - sb2; v = (s > SMAX) || (s < SMIN); c = (a >= b); upd = 1'b1; end
            ALU_AND:  begin r = a & b; upd = 1'b1; end
            ALU_OR:   r = a | b;
            ALU_PASS: r = b;
            ALU_LSL:  begin r = a << sh; e.lat = sh; end
            ALU_LSR:  begin r = a >> sh; e.lat = sh; end
            default:  e.ill = 1'b1;
        endcase
        if (sf && upd) mflags = {r[63], r == 64'd0, v, c};
        e.res = r;
        e.flg = mflags;
    endtask

    task automatic issue(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] sh, input logic sf, output int acc);
        exp_t e;
        int waited = 0;
        acc = -1;
        bus.alu_ctl = ctl; bus.op_a = a; bus.op_b = b; bus.shamt = sh; bus.set_flags = sf;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 200) begin
                chk_cnt++;
                $display("FAIL accept_timeout: in_ready stayed %b, required 1 within 200 cycles", bus.in_ready);
                break;
            end
        end
        if (waited <= 200) begin
            model(ctl, a, b, sh, sf, e);
            e.acc = cyc + 1;
            acc = e.acc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, bus.out_valid, 64'd0);
        check({tag, "_in_ready"},  bus.in_ready,  64'd1);
        check({tag, "_result"},    bus.result,    64'd0);
        check({tag, "_flags"},     bus.flags,     64'd0);
        check({tag, "_zero"},      bus.zero,      64'd1);
        check({tag, "_illegal"},   bus.illegal,   64'd0);
    endtask

    // out_ready driver, moved after the driver's own updates in each cycle.
    always @(posedge clk) begin
        #2;
        if (!ready_force) bus.out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops and compares on each completed output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            need_start = 1'b1;
        end else begin
            if (bus.out_valid && need_start) begin
                start_cyc = cyc;
                need_start = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL spurious_out: out_valid=1 result %h with no operation outstanding", bus.result);
                end else begin
                    e = sb.pop_front();
                    check("result",  bus.result,  e.res);
                    check("flags",   bus.flags,   e.flg);
                    check("illegal", bus.illegal, e.ill);
                    check("zero",    bus.zero,    e.res == 64'd0);
                    check("latency", start_cyc - e.acc, e.lat);
                end
                need_start = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, ad;
        logic [3:0]  ctl;
        logic [63:0] a, b;
        logic [3:0]  codes [8];
        codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASS, ALU_LSL, ALU_LSR, ALU_NONE};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.alu_ctl = '0; bus.op_a = '0; bus.op_b = '0;
        bus.shamt = '0; bus.set_flags = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        reset_checks("reset");
        @(posedge clk); #1;

        issue(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b1, a0);
        issue(ALU_SUB, 64'd5, 64'd5, 6'd0, 1'b1, a0);
        issue(ALU_SUB, 64'd3, 64'd5, 6'd0, 1'b1, a0);
        drain();
        issue(ALU_LSL, 64'd1, 64'd0, 6'd63, 1'b0, a0);
        issue(ALU_LSR, 64'hF0, 64'd0, 6'd4, 1'b0, a0);
        drain();

        issue(ALU_AND, 64'hFF00_FF00_1234_5678, 64'h0F0F_0F0F_FFFF_0000, 6'd0, 1'b1, a0);
        issue(ALU_OR,  64'h0000_0000_0000_00F0, 64'h8000_0000_0000_000F, 6'd0, 1'b0, a1);
        issue(ALU_PASS, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 6'd0, 1'b0, a2);
        check("b2b_gap1", a1 - a0, 64'd1);
        check("b2b_gap2", a2 - a1, 64'd1);
        ready_force = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hold_out_valid", bus.out_valid, 64'd1);
            check("hold_result",    bus.result,    64'hDEAD_BEEF_CAFE_F00D);
            check("hold_in_ready",  bus.in_ready,  64'd0);
            check("hold_flags",     bus.flags,     mflags);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        ready_force = 1'b0;
        drain();

        issue(ALU_NONE, 64'd7, 64'd9, 6'd0, 1'b1, a0);
        drain();

        issue(ALU_LSL, 64'h1, 64'd0, 6'd40, 1'b0, a0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        mflags = 4'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        reset_checks("midshift_reset");
        @(posedge clk); #1;
        issue(ALU_ADD, 64'd2, 64'd3, 6'd0, 1'b0, a0);
        drain();

        random_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            ctl = ($urandom_range(0, 9) == 0) ? 4'($urandom) : codes[$urandom_range(0, 7)];
            a = ($urandom_range(0, 3) == 0) ? 64'h8000_0000_0000_0000 - 64'($urandom_range(0, 1)) : {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            issue(ctl, a, b, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), ad);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();
        random_ready = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
